// File: rtl/ysyx_23060201_lsu_pkg.sv
// rtl/ysyx_23060201_lsu_pkg.sv - LSU state encoding, funct3 codes, byte-lane mask constants
// Contents: lsu_state_e, funct3 localparams, base masks, width/misalignment helpers.
package ysyx_23060201_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_RD   = 2'd1,
    LSU_WR   = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;

  // Unlisted funct3 codes fall through to word width.
  function automatic logic [7:0] lsu_base_mask(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: lsu_base_mask = MASK_B;
      F3_LH, F3_LHU: lsu_base_mask = MASK_H;
      default:       lsu_base_mask = MASK_W;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_LB, F3_LBU: lsu_misaligned = 1'b0;
      F3_LH, F3_LHU: lsu_misaligned = offset[0];
      default:       lsu_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// rtl/ysyx_23060201_lsu_align.sv - byte-lane mask, store data shift, load extract/extend
// Ports: funct3/offset select width and lane; wdata -> wdata_sh; rdata -> rdata_ext; mask is the lane mask.
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [7:0]  mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_sh;

  always_comb begin
    // 8-bit shift: lanes pushed past bit 7 are simply dropped.
    mask     = lsu_base_mask(funct3) << offset;
    wdata_sh = wdata << {offset, 3'b000};
    rdata_sh = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      F3_LH:   rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      F3_LBU:  rdata_ext = {24'b0, rdata_sh[7:0]};
      F3_LHU:  rdata_ext = {16'b0, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// rtl/ysyx_23060201_lsu.sv - load/store unit, single outstanding data-memory access
// Ports: req_* from EXU (valid/ready), rsp_* to WBU (valid/ready), mem_* read/write port to data memory.
// Option: define LSU_MISALIGN_CHECK_EN to answer misaligned H/W accesses with rsp_err instead of a memory access.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]            mem_rmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  lsu_state_e            state_q, state_d;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            lane_mask;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rdata_ext;
  logic                  accept;
  logic                  bad_align;

  assign accept = req_valid && (state_q == LSU_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;
  assign bad_align = lsu_misaligned(req_funct3, req_addr[1:0]);
  assign rsp_err   = err_q;
`else
  assign bad_align = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  ysyx_23060201_lsu_align u_align (
    .funct3    (funct3_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .mask      (lane_mask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept) state_d = bad_align ? LSU_RESP : (req_wen ? LSU_WR : LSU_RD);
      LSU_RD:   if (mem_rvalid) state_d = LSU_RESP;
      LSU_WR:   state_d = LSU_RESP;
      LSU_RESP: if (rsp_ready) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Request fields and the result register; the result is cleared on accept so
  // stores and skipped accesses answer with zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else if (accept) begin
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q    <= bad_align;
`endif
    end else if (state_q == LSU_RD && mem_rvalid) begin
      rdata_q <= rdata_ext;
    end
  end

  assign req_ready = (state_q == LSU_IDLE);
  assign rsp_valid = (state_q == LSU_RESP);
  assign rsp_rdata = rdata_q;
  assign mem_ren   = (state_q == LSU_RD);
  assign mem_wen   = (state_q == LSU_WR);
  assign mem_raddr = mem_ren ? addr_q : '0;
  assign mem_rmask = mem_ren ? lane_mask : 8'h00;
  assign mem_waddr = mem_wen ? addr_q : '0;
  assign mem_wmask = mem_wen ? lane_mask : 8'h00;
  assign mem_wdata = mem_wen ? wdata_sh : '0;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// tb/tb_ysyx_23060201_lsu.sv - self-checking bench for ysyx_23060201_lsu
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_ren, mem_wen, mem_rvalid;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [7:0]  mem_rmask, mem_wmask;

  always #5 clk = ~clk;

  ysyx_23060201_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata)
  );

  int checks = 0;
  int errors = 0;

  // Expected behaviour of the transaction in flight.
  logic        mon_en = 1'b0;
  logic        busy = 1'b0;
  logic        exp_load, exp_skip, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [7:0]  exp_mask;
  int          ren_seen, wen_cnt;
  logic [31:0] last_rdata, last_wdata, last_waddr;
  logic [7:0]  last_rmask, last_wmask;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one access must look like, computed from the width/lane rules.
  task automatic set_model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word);
    int unsigned off, size, base;
    logic [31:0] sh, v;
    off = addr & 3;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    base = (1 << size) - 1;
    exp_mask = 8'((base << off) & 32'hFF);
`ifdef LSU_MISALIGN_CHECK_EN
    exp_skip = (size == 2 && (off % 2) != 0) || (size == 4 && off != 0);
`else
    exp_skip = 1'b0;
`endif
    exp_err   = exp_skip;
    exp_load  = !wen;
    exp_addr  = addr;
    exp_wdata = wdata << (8 * off);
    sh = word >> (8 * off);
    case (f3)
      3'd0: begin v = sh % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      3'd4: v = sh % 256;
      3'd1: begin v = sh % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd5: v = sh % 65536;
      default: v = sh;
    endcase
    exp_rdata = (wen || exp_skip) ? 32'h0 : v;
  endtask

  // Cycle-by-cycle compare against the expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ren_wen_exclusive", {31'b0, mem_ren && mem_wen}, 32'h0);
      if (!busy) begin
        chk("idle_req_ready", {31'b0, req_ready}, 32'h1);
        chk("idle_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("idle_mem_ren", {31'b0, mem_ren}, 32'h0);
        chk("idle_mem_wen", {31'b0, mem_wen}, 32'h0);
      end else begin
        chk("busy_req_ready", {31'b0, req_ready}, 32'h0);
        if (mem_ren) begin
          ren_seen++;
          chk("ren_allowed", {31'b0, exp_load && !exp_skip}, 32'h1);
          chk("mem_raddr", mem_raddr, exp_addr);
          chk("mem_rmask", {24'b0, mem_rmask}, {24'b0, exp_mask});
          last_rmask = mem_rmask;
        end
        if (mem_wen) begin
          wen_cnt++;
          chk("wen_allowed", {31'b0, !exp_load && !exp_skip}, 32'h1);
          chk("mem_waddr", mem_waddr, exp_addr);
          chk("mem_wmask", {24'b0, mem_wmask}, {24'b0, exp_mask});
          chk("mem_wdata", mem_wdata, exp_wdata);
          last_wmask = mem_wmask;
          last_wdata = mem_wdata;
          last_waddr = mem_waddr;
        end
        if (rsp_valid) begin
          chk("rsp_rdata", rsp_rdata, exp_rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
        end
      end
    end
  end

  task automatic do_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int rdly, input int ydly, output int rsp_wait);
    int n;
    @(posedge clk); #1;
    set_model(wen, f3, addr, wdata, word);
    ren_seen = 0;
    wen_cnt = 0;
    req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
    busy = 1'b1;
    if (!wen) begin
      repeat (rdly) begin @(posedge clk); #1; end
      mem_rdata = word;
      mem_rvalid = 1'b1;
    end
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    rsp_wait = n;
    chk("rsp_valid_timeout", {31'b0, rsp_valid}, 32'h1);
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    repeat (ydly) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    busy = 1'b0;
    chk("wen_pulses", wen_cnt, (wen && !exp_skip) ? 1 : 0);
    chk("ren_seen", {31'b0, ren_seen > 0}, {31'b0, !wen && !exp_skip});
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("reset_mem_en", {30'b0, mem_ren, mem_wen}, 32'h0);
    chk("reset_addrs", mem_raddr | mem_waddr | mem_wdata, 32'h0);
    chk("reset_masks", {16'b0, mem_rmask, mem_wmask}, 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    do_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h8012_3456, 0, 0, w);
    chk("lb_rmask", {24'b0, last_rmask}, 32'h08);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);

    do_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 1, 1, w);
    chk("lhu_rmask", {24'b0, last_rmask}, 32'h0C);
    chk("lhu_rdata", last_rdata, 32'h0000_BEEF);

    do_txn(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 0, 0, w);
    chk("sb_wen_pulses", wen_cnt, 1);
    chk("sb_wmask", {24'b0, last_wmask}, 32'h02);
    chk("sb_wdata", last_wdata, 32'h0000_AB00);
    chk("sb_waddr", last_waddr, 32'h8000_0001);

    do_txn(1'b0, 3'b010, 32'h8000_0100, 32'h0, 32'hCAFE_F00D, 3, 2, w);
    chk("lw_rdata", last_rdata, 32'hCAFE_F00D);

`ifdef LSU_MISALIGN_CHECK_EN
    do_txn(1'b1, 3'b010, 32'h8000_0002, 32'h1234_5678, 32'h0, 0, 0, w);
    chk("sw_misalign_wen", wen_cnt, 0);
    chk("sw_misalign_err", {31'b0, last_err}, 32'h1);
    chk("sw_misalign_latency", w, 0);
`endif

    // Reset while a read is waiting on memory.
    @(posedge clk); #1;
    set_model(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h0);
    req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0040; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    busy = 1'b1;
    @(posedge clk); #1;
    chk("rd_pending_ren", {31'b0, mem_ren}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy = 1'b0;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("midrst_mem_ren", {31'b0, mem_ren}, 32'h0);

    for (int i = 0; i < 150; i++) begin
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), w);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
